// File: rtl/phase_clock_bank.sv
// rtl/phase_clock_bank.sv - shared-counter multi-channel phase/duty clock bank
// Shadow settings commit together at the period wrap so every channel changes in the same cycle.
module phase_clock_bank #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int CHAN_W   = 3
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_phase,
  input  logic [WIDTH-1:0]    cfg_duty,
  input  logic                period_wr,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                update_req,
  output logic                update_pending,
  output logic                sync_out,
  output logic [CHANNELS-1:0] clock_out
);

  localparam logic [WIDTH-1:0] PERIOD_RST = '1;
  localparam logic [WIDTH-1:0] DUTY_RST   = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    act_period;
  logic [WIDTH-1:0]    shd_period;
  logic [WIDTH-1:0]    act_phase [CHANNELS];
  logic [WIDTH-1:0]    act_duty  [CHANNELS];
  logic [WIDTH-1:0]    shd_phase [CHANNELS];
  logic [WIDTH-1:0]    shd_duty  [CHANNELS];
  logic [CHANNELS-1:0] level;
  logic                wrap;
  logic                commit;

  // >= rather than == keeps the counter bounded even if it ever exceeds the period
  assign wrap   = (count >= act_period);
  assign commit = update_pending && (!enable || wrap);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH:0] diff;
    assign diff = (count >= act_phase[i])
                ? {1'b0, count} - {1'b0, act_phase[i]}
                : {1'b0, count} + {1'b0, act_period} + (WIDTH+1)'(1) - {1'b0, act_phase[i]};
    assign level[i] = (act_phase[i] <= act_period) && (diff < {1'b0, act_duty[i]});
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      act_period     <= PERIOD_RST;
      shd_period     <= PERIOD_RST;
      update_pending <= 1'b0;
      sync_out       <= 1'b0;
      clock_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        act_phase[i] <= '0;
        act_duty[i]  <= DUTY_RST;
        shd_phase[i] <= '0;
        shd_duty[i]  <= DUTY_RST;
      end
    end else begin
      count          <= (!enable || wrap) ? '0 : count + WIDTH'(1);
      update_pending <= update_req || (update_pending && !commit);
      sync_out       <= enable && (count == '0);
      clock_out      <= enable ? level : '0;
      if (commit) begin
        act_period <= shd_period;
      end
      if (period_wr) begin
        shd_period <= period_in;
      end
      // Actives load the pre-edge shadows, so a same-edge write stays for the next commit
      for (int i = 0; i < CHANNELS; i++) begin
        if (commit) begin
          act_phase[i] <= shd_phase[i];
          act_duty[i]  <= shd_duty[i];
        end
        if (cfg_wr && (cfg_chan == CHAN_W'(i))) begin
          shd_phase[i] <= cfg_phase;
          shd_duty[i]  <= cfg_duty;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_clock_bank.sv
// tb/tb_phase_clock_bank.sv - randomized bench for phase_clock_bank against a behavioural model
module tb_phase_clock_bank;
  localparam int CH = 6;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clock_in = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [CW-1:0] cfg_chan = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic [W-1:0]  cfg_duty = '0;
  logic          period_wr = 1'b0;
  logic [W-1:0]  period_in = '0;
  logic          update_req = 1'b0;
  logic          update_pending;
  logic          sync_out;
  logic [CH-1:0] clock_out;

  int total = 0;
  int bad = 0;

  int m_cnt, m_pa, m_ps;
  int m_ph [CH];
  int m_d  [CH];
  int s_ph [CH];
  int s_d  [CH];
  bit m_pend;
  logic [CH-1:0] e_out;
  bit e_sync;

  phase_clock_bank #(.CHANNELS(CH), .WIDTH(W), .CHAN_W(CW)) dut (
    .clock_in(clock_in), .reset(reset), .enable(enable),
    .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_phase(cfg_phase), .cfg_duty(cfg_duty),
    .period_wr(period_wr), .period_in(period_in), .update_req(update_req),
    .update_pending(update_pending), .sync_out(sync_out), .clock_out(clock_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pa = (1 << W) - 1; m_ps = m_pa; m_pend = 0;
    e_out = '0; e_sync = 0;
    for (int i = 0; i < CH; i++) begin
      m_ph[i] = 0; s_ph[i] = 0; m_d[i] = 1 << (W - 1); s_d[i] = 1 << (W - 1);
    end
  endtask

  // A channel is high while its distance past the phase, modulo the period length, is under duty
  task automatic model_edge();
    bit commit;
    commit = m_pend && (!enable || m_cnt == m_pa);
    for (int i = 0; i < CH; i++)
      e_out[i] = enable && (m_ph[i] <= m_pa) &&
                 (((m_cnt - m_ph[i] + m_pa + 1) % (m_pa + 1)) < m_d[i]);
    e_sync = enable && (m_cnt == 0);
    m_cnt = enable ? (m_cnt + 1) % (m_pa + 1) : 0;
    if (commit) begin
      m_pa = m_ps;
      for (int i = 0; i < CH; i++) begin m_ph[i] = s_ph[i]; m_d[i] = s_d[i]; end
    end
    if (period_wr) m_ps = period_in;
    if (cfg_wr && cfg_chan < CH) begin s_ph[cfg_chan] = cfg_phase; s_d[cfg_chan] = cfg_duty; end
    m_pend = update_req || (m_pend && !commit);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      model_edge();
      #1;
      check("clock_out", clock_out, e_out);
      check("sync_out", sync_out, e_sync);
      check("update_pending", update_pending, m_pend);
    end
  endtask

  task automatic write_cfg(input int ch, input int ph, input int d);
    cfg_chan = CW'(ch); cfg_phase = W'(ph); cfg_duty = W'(d); cfg_wr = 1'b1;
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic request_update();
    update_req = 1'b1;
    step(1);
    update_req = 1'b0;
  endtask

  initial begin
    bit found;
    model_reset();
    #12;
    check("reset_clock_out", clock_out, '0);
    check("reset_sync", sync_out, 1'b0);
    check("reset_pending", update_pending, 1'b0);
    reset = 1'b1;
    enable = 1'b1;
    step(600);

    // period 10 and ch2 phase 3 duty 5 written alongside the request
    period_in = 8'd9; period_wr = 1'b1;
    cfg_chan = 3'd2; cfg_phase = 8'd3; cfg_duty = 8'd5; cfg_wr = 1'b1;
    update_req = 1'b1;
    step(1);
    period_wr = 1'b0; cfg_wr = 1'b0; update_req = 1'b0;
    step(300);

    write_cfg(1, 8, 4);
    write_cfg(3, 0, 0);
    write_cfg(4, 0, 10);
    write_cfg(5, 12, 5);
    write_cfg(6, 1, 1);
    write_cfg(7, 2, 2);
    request_update();
    step(40);

    // collide cfg_wr and update_req with a commit edge
    request_update();
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (m_pend && m_cnt == m_pa) found = 1;
      else step(1);
    end
    check("wait_boundary", 32'(found), 32'd1);
    cfg_chan = 3'd3; cfg_phase = 8'd1; cfg_duty = 8'd2; cfg_wr = 1'b1; update_req = 1'b1;
    step(1);
    cfg_wr = 1'b0; update_req = 1'b0;
    step(30);

    // enable drop with an update pending
    step(4);
    write_cfg(0, 2, 3);
    request_update();
    step(1);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    step(30);

    repeat (2000) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_wr = 1'b1; cfg_chan = CW'($urandom_range(0, 7));
        cfg_phase = W'($urandom_range(0, 15)); cfg_duty = W'($urandom_range(0, 17));
      end
      if ($urandom_range(0, 7) == 0) begin
        period_wr = 1'b1; period_in = W'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) update_req = 1'b1;
      if ($urandom_range(0, 59) == 0) enable = !enable;
      step(1);
      cfg_wr = 1'b0; period_wr = 1'b0; update_req = 1'b0;
    end

    // asynchronous reset mid-period with an update pending
    enable = 1'b1;
    request_update();
    step(3);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midreset_clock_out", clock_out, '0);
    check("midreset_sync", sync_out, 1'b0);
    check("midreset_pending", update_pending, 1'b0);
    #3 reset = 1'b1;
    step(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
